// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-cycle initiator.
// Takes one read/write command on a valid/ready command port, runs exactly
// one Wishbone cycle for it, and returns read data / error status on a
// valid/ready response port. At most one bus cycle is ever outstanding.
//
// Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN
//   When defined, a TIMEOUT_W-bit counter terminates a bus cycle that sees
//   no ack/err after TIMEOUT_CYCLES waits and reports it as an error.
//   When undefined, the bus cycle waits indefinitely for ack/err.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready is combinational)
//   cmd_we/adr/dat/sel         command payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_dat/rsp_err            response payload (rsp_dat=0 for writes/errors)
//   busy                       high whenever not idle
//   wbm_*                      Wishbone initiator interface
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    // Reject timeout settings that the counter cannot reach.
    if (TIMEOUT_CYCLES == 0 || (TIMEOUT_CYCLES >> TIMEOUT_W) != 0) begin : g_bad_cfg
        $error("wb_cmd_master: TIMEOUT_CYCLES out of range for TIMEOUT_W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_dat_q;
    logic        busy_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
`endif

    assign cmd_ready = (state_q == S_IDLE);

    // Command -> single bus cycle -> response sequencer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 32'h0;
            busy_q      <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_q <= S_BUS;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= cmd_we;
                        sel_q   <= cmd_sel;
                        // Word-aligned bus address.
                        adr_q   <= {cmd_adr[31:2], 2'b00};
                        dat_q   <= cmd_dat;
                        busy_q  <= 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                S_BUS: begin
                    // err has priority over ack; both beat the timeout.
                    if (wbm_err_i) begin
                        state_q     <= S_RESP;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_dat_q   <= 32'h0;
                    end else if (wbm_ack_i) begin
                        state_q     <= S_RESP;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_dat_q   <= we_q ? 32'h0 : wbm_dat_i;
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    else if (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                        state_q     <= S_RESP;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_dat_q   <= 32'h0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: self-checking bench for wb_cmd_master (default build).
// A transaction-level model derives the expected bus address, bus-phase
// duration and response from each command and the slave's chosen reply.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    wb_cmd_master dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full command: accept, bus phase of (waits+1) strobe cycles,
    // response held for bp cycles of back-pressure, then taken.
    // Called and returns at a falling edge with the DUT idle.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int waits, input logic t_err,
                          input logic t_ack, input logic [31:0] rd, input int bp,
                          input logic hold_next);
        logic [31:0] exp_adr;
        logic [31:0] exp_rsp;
        exp_adr = adr & 32'hFFFF_FFFC;
        exp_rsp = t_err ? 32'h0 : (we ? 32'h0 : rd);

        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(negedge clk);
        // Scramble the command inputs to prove the payload was captured.
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);

        for (int w = 0; w <= waits; w++) begin
            chk("bus_cyc", 32'(wbm_cyc_o), 32'd1);
            chk("bus_stb", 32'(wbm_stb_o), 32'd1);
            chk("bus_we", 32'(wbm_we_o), 32'(we));
            chk("bus_sel", 32'(wbm_sel_o), 32'(sel));
            chk("bus_adr", wbm_adr_o, exp_adr);
            chk("bus_dat", wbm_dat_o, dat);
            chk("bus_busy", 32'(busy), 32'd1);
            chk("bus_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bus_rsp_valid", 32'(rsp_valid), 32'd0);
            if (w == waits) begin
                wbm_dat_i = rd;
                wbm_err_i = t_err;
                wbm_ack_i = t_ack;
            end else begin
                wbm_dat_i = $urandom;
                wbm_err_i = 1'b0;
                wbm_ack_i = 1'b0;
            end
            rsp_ready = 1'($urandom);
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = $urandom;

        chk("term_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("term_stb", 32'(wbm_stb_o), 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_dat", rsp_dat, exp_rsp);
        chk("rsp_err", 32'(rsp_err), 32'(t_err));

        for (int b = 0; b < bp; b++) begin
            rsp_ready = 1'b0;
            if (hold_next) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'($urandom);
                cmd_adr   = $urandom;
                cmd_dat   = $urandom;
                cmd_sel   = 4'($urandom);
            end
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_dat", rsp_dat, exp_rsp);
            chk("bp_rsp_err", 32'(rsp_err), 32'(t_err));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_cyc", 32'(wbm_cyc_o), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("taken_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("taken_rsp_err", 32'(rsp_err), 32'd0);
        chk("taken_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("taken_busy", 32'(busy), 32'd0);
        chk("taken_cyc", 32'(wbm_cyc_o), 32'd0);
    endtask

    // Idle cycles with stray ack/err that must be ignored.
    task automatic idle_noise(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wbm_ack_i = 1'($urandom);
            wbm_err_i = 1'($urandom);
            @(negedge clk);
            chk("noise_cyc", 32'(wbm_cyc_o), 32'd0);
            chk("noise_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("noise_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
    endtask

    initial begin
        logic [31:0] adr;
        logic        e;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_err, busy, cmd_ready}, 32'b0001);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait write, unaligned address.
        do_txn(1'b1, 32'h3000_0007, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b1, 32'hAAAA_5555, 0, 1'b0);
        // Read with 3 wait states.
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 1'b0, 1'b1, 32'h1234_5678, 0, 1'b0);
        // err and ack together: err wins.
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
        // Back-pressure with a pending command that must wait.
        do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 0, 1'b0, 1'b1, 32'hCAFE_F00D, 5, 1'b1);
        // The held command is consumed right after the response is taken.
        do_txn(1'b1, 32'h3000_0028, 32'h0BAD_F00D, 4'h0, 0, 1'b0, 1'b1, 32'h1, 0, 1'b0);
        idle_noise(3);

        // Reset in the middle of a bus cycle.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_stb", 32'(wbm_stb_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("async_rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_noise(3);
        do_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 1'b0, 1'b1, 32'h7654_3210, 1, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            adr = $urandom;
            e   = ($urandom_range(0, 3) == 0);
            do_txn(1'($urandom), adr, $urandom, 4'($urandom), int'($urandom_range(0, 4)),
                   e, e ? 1'($urandom) : 1'b1, $urandom, int'($urandom_range(0, 3)),
                   1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_noise(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic single-cycle initiator; the master-side counterpart to the user-area Wishbone slaves.
- Accepts one read/write command on a valid/ready command port and runs exactly one Wishbone cycle per command.
- Returns read data or error status on a valid/ready response port.
- Used to drive user-area slaves (counter/register blocks) from LA probes or an internal sequencer, without the management SoC.

Parameters:
- TIMEOUT_CYCLES, 255: max wait cycles for ack/err (used only with the optional feature); legal range 1..(2^TIMEOUT_W)-1.
- TIMEOUT_W, 8: width of the timeout counter.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  bus error, or timeout when the optional feature is compiled in.
- busy  out  1  high in any state other than IDLE.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_err_i  in  1  Wishbone error.

Behaviour:
- Reset values (asynchronous, take effect immediately): state=IDLE; cyc, stb, we, rsp_valid, rsp_err, busy = 0; sel=0; adr, dat_o, rsp_dat = 0.
- All outputs are registered, except cmd_ready = (state==IDLE).
- IDLE:
  - cmd_ready=1.
  - When cmd_valid&cmd_ready on an edge: capture we/sel/dat; capture adr with bits [1:0] forced to 00. Go to BUS.
  - wbm_cyc_o and wbm_stb_o rise on that same edge, so they are visible in the cycle after acceptance.
- BUS:
  - cyc=stb=1; adr/we/sel/dat_o held stable until termination.
  - On an edge where ack_i=1 or err_i=1: cyc and stb drop on that edge, then go to RESP.
  - If err_i=1: rsp_err=1 and rsp_dat=0. Err wins if ack_i and err_i are both high.
  - Else, for a read: rsp_dat=wbm_dat_i. For a write: rsp_dat=0.
  - No pipelining: at most one outstanding cycle.
- RESP:
  - rsp_valid=1; rsp_dat and rsp_err held.
  - On an edge with rsp_ready=1: rsp_valid=0 and rsp_err=0, go to IDLE.
  - A new command is accepted no earlier than the cycle after the response is taken. Minimum command-to-command period is 3 cycles with zero-wait ack and rsp_ready held high.
- Latency: acceptance edge T0; stb high during cycle T0+1. An ack during T0+1 gives rsp_valid high during T0+2.
- ack_i/err_i arriving in IDLE or RESP are ignored; no state change.
- cmd_sel=0 is legal and issued as-is.
- wb_rst_i asserted during BUS drops cyc/stb asynchronously. The in-flight command is lost and no response is produced.
- cmd_valid held during BUS/RESP is not consumed (cmd_ready=0).

Optional Feature:
- Macro: WB_CMD_MASTER_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_W-bit counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When the counter reaches TIMEOUT_CYCLES and ack/err are both low: drop cyc/stb, rsp_err=1, rsp_dat=0, go to RESP.
  - An ack/err on the same edge as the timeout takes priority over the timeout.
- When not defined: no counter is instantiated; BUS waits indefinitely for ack/err.

Test Plan:
- Write: cmd we=1, adr=0x30000007, dat=0xDEADBEEF, sel=0xF; slave acks in first stb cycle -> wbm_adr_o=0x30000004, wbm_dat_o=0xDEADBEEF, stb high exactly 1 cycle; rsp_valid 2 cycles after accept, rsp_dat=0, rsp_err=0.
- Read with 3 wait states: slave returns 0x12345678 -> cyc/stb high 4 cycles, all outputs stable; rsp_dat=0x12345678, rsp_err=0.
- Error: slave asserts err_i and ack_i together -> rsp_err=1, rsp_dat=0; cyc drops same edge.
- Back-pressure: rsp_ready low 5 cycles -> rsp_valid and rsp_dat held, cmd_ready=0, second cmd_valid not consumed; consumed 1 cycle after rsp_ready.
- Reset during BUS: wb_rst_i pulsed mid-cycle -> cyc/stb=0 immediately, no rsp_valid; next command completes normally.
- With WB_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4: slave never acks -> stb high 5 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0.
